// File: rtl/led_bank_arbiter.sv
// rtl/led_bank_arbiter.sv - round-robin LED bank arbiter with min/max display hold
module led_bank_arbiter #(
  parameter int NREQ     = 3,
  parameter int NLED     = 9,
  parameter int PRESC_W  = 18,
  parameter int MIN_HOLD = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*NLED-1:0] pat,
  output logic [NREQ-1:0]      gnt,
  output logic [NLED-1:0]      leds,
  output logic                 tick
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MIN_H = HW'(MIN_HOLD);
  localparam logic [HW-1:0] MAX_H = HW'(MAX_HOLD);
  localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [PRESC_W-1:0] presc;
  logic              hb;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic [LW-1:0]     last, last_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic [NLED-1:0]   leds_nxt;
  logic [NREQ-1:0]   own_mask;
  logic              others;
  logic              release_now;
  logic [LW:0]       pick;

  // Round-robin scan starting after base; optionally excludes base itself.
  // Returns {found, index}; the lowest scan offset wins.
  function automatic logic [LW:0] rr_pick(input logic [NREQ-1:0] r,
                                          input logic [LW-1:0]   base,
                                          input logic            skip_base);
    logic [LW:0] res;
    int          idx;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(base) + k) % NREQ;
      if (r[idx] && !(skip_base && k == NREQ))
        res = {1'b1, LW'(idx)};
    end
    return res;
  endfunction

  // While granted, last holds the current owner.
  assign own_mask    = NREQ'(1) << last;
  assign others      = |(req & ~own_mask);
  assign release_now = (!req[last] && hold_cnt >= MIN_H) ||
                       (hold_cnt >= MAX_H && others);

  // Free-running prescaler; tick is the registered wrap pulse, hb the idle heartbeat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc <= '0;
      tick  <= 1'b0;
      hb    <= 1'b0;
    end else begin
      presc <= presc + 1'b1;
      tick  <= &presc;
      if (tick) hb <= ~hb;
    end
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      gnt      <= '0;
      leds     <= '0;
      hold_cnt <= '0;
      last     <= LAST_RST;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      leds     <= leds_nxt;
      hold_cnt <= hold_nxt;
      last     <= last_nxt;
    end
  end

  // Next-state: pick, hold, release and regrant decisions.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    leds_nxt  = leds;
    hold_nxt  = hold_cnt;
    last_nxt  = last;
    pick      = '0;
    case (state)
      IDLE: begin
        leds_nxt = {{(NLED-1){1'b0}}, hb};
        pick     = rr_pick(req, last, 1'b0);
        if (pick[LW]) begin
          state_nxt = GRANT;
          gnt_nxt   = NREQ'(1) << pick[LW-1:0];
          last_nxt  = pick[LW-1:0];
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        // A dropped request freezes the display at its last pattern.
        if (req[last])
          leds_nxt = pat[int'(last)*NLED +: NLED];
        if (release_now) begin
          hold_nxt = '0;
          if (others) begin
            // Direct handover: no idle gap between owners.
            pick     = rr_pick(req, last, 1'b1);
            gnt_nxt  = NREQ'(1) << pick[LW-1:0];
            last_nxt = pick[LW-1:0];
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end else if (tick && hold_cnt < MAX_H) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

endmodule
